// File: rtl/div_pkg.sv
// Shared types and constants for the iterative Newton-Raphson divider slice.
package div_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = 16;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  localparam data_t CONST_TWO = 8'sd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/div_iter_ctrl_if.sv
// Operand request / result handshake bundle for div_iter_ctrl.
interface div_iter_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  import div_pkg::*;

  logic             start;
  logic             ready;
  data_t            a_in;
  data_t            b_in;
  data_t            x0_in;
  logic             flush;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  prod_t            q_out;
  data_t            x_out;
  logic [CNT_W-1:0] iter_cnt;
  logic             converged;
  logic             div_err;

  // Operand source / result consumer side
  modport master (
    output start, a_in, b_in, x0_in, flush, out_ready,
    input  ready, busy, out_valid, q_out, x_out, iter_cnt, converged, div_err
  );

  // Controller side
  modport slave (
    input  start, a_in, b_in, x0_in, flush, out_ready,
    output ready, busy, out_valid, q_out, x_out, iter_cnt, converged, div_err
  );

endinterface

// File: rtl/divider.sv
// Combinational Newton-Raphson stage: Ni = A*xi, Di = B*xi, xinew = (2 - Di[7:0])*xi.
module divider import div_pkg::*; (
  input  data_t A,
  input  data_t B,
  input  data_t xi,
  output prod_t Ni,
  output prod_t Di,
  output prod_t xinew
);

  data_t two_minus_di;

  assign Ni           = prod_t'(A) * prod_t'(xi);
  assign Di           = prod_t'(B) * prod_t'(xi);
  // Only the low byte of Di enters the correction term; wraps like the original stage
  assign two_minus_di = CONST_TWO - data_t'(Di[DATA_W-1:0]);
  assign xinew        = prod_t'(two_minus_di) * prod_t'(xi);

endmodule

// File: rtl/div_iter_ctrl.sv
// Sequential controller that iterates the shared divider stage until x settles
// or the iteration budget runs out, then presents A*x_final on a valid/ready port.
module div_iter_ctrl import div_pkg::*; #(
  parameter int unsigned MAX_ITER = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  div_iter_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_t           state_q;
  data_t            a_q;
  data_t            b_q;
  data_t            x_q;
  logic [CNT_W-1:0] cnt_q;
  logic             conv_pend_q;
  logic             ready_q;
  logic             busy_q;
  logic             valid_q;
  prod_t            q_out_q;
  data_t            x_out_q;
  logic             conv_q;
  logic             err_q;

  prod_t            stage_ni;
  prod_t            stage_di;
  prod_t            stage_xinew;
  data_t            x_d;
  logic [CNT_W-1:0] cnt_d;
  logic             unused_stage;

  // One stage instance, time-shared between the ITER updates and the FIN product
  divider u_stage (
    .A     (a_q),
    .B     (b_q),
    .xi    (x_q),
    .Ni    (stage_ni),
    .Di    (stage_di),
    .xinew (stage_xinew)
  );

  assign x_d          = data_t'(stage_xinew[DATA_W-1:0]);
  assign cnt_d        = cnt_q + 1'b1;
  assign unused_stage = ^{stage_di, stage_xinew[PROD_W-1:DATA_W]};

  // FSM, iteration counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      cnt_q       <= '0;
      conv_pend_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      q_out_q     <= '0;
      x_out_q     <= '0;
      conv_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.flush && bus.start) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            x_q     <= bus.x0_in;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            if (bus.b_in == '0) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
              q_out_q <= '0;
              x_out_q <= '0;
              conv_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= ITER;
              busy_q  <= 1'b1;
            end
          end
        end
        ITER, FIN: begin
          if (bus.flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            q_out_q <= '0;
            x_out_q <= '0;
            conv_q  <= 1'b0;
            err_q   <= 1'b0;
          end else if (state_q == ITER) begin
            x_q   <= x_d;
            cnt_q <= cnt_d;
            // Stop reason is parked here and published with the rest of the result at FIN
            if (x_d == x_q) begin
              state_q     <= FIN;
              conv_pend_q <= 1'b1;
            end else if (cnt_d == MAX_CNT) begin
              state_q     <= FIN;
              conv_pend_q <= 1'b0;
            end
          end else begin
            state_q <= HOLD;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            q_out_q <= stage_ni;
            x_out_q <= x_q;
            conv_q  <= conv_pend_q;
            err_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.out_ready || bus.flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.q_out     = q_out_q;
  assign bus.x_out     = x_out_q;
  assign bus.iter_cnt  = cnt_q;
  assign bus.converged = conv_q;
  assign bus.div_err   = err_q;

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Scoreboard bench for div_iter_ctrl: two instances (MAX_ITER 8 and 3) share one stimulus stream.
module tb_div_iter_ctrl;

  typedef struct {
    logic signed [15:0] q;
    logic signed [7:0]  x;
    logic [3:0]         cnt;
    logic               conv;
    logic               err;
    int                 lat;
    int                 acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic signed [7:0] a_in = '0;
  logic signed [7:0] b_in = '0;
  logic signed [7:0] x0_in = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t sb8[$];
  exp_t sb3[$];
  bit   have[2];
  bit   bogus[2];
  exp_t cur[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_iter_ctrl_if #(.CNT_W(4)) bus8 ();
  div_iter_ctrl_if #(.CNT_W(4)) bus3 ();

  assign bus8.start = start;      assign bus3.start = start;
  assign bus8.flush = flush;      assign bus3.flush = flush;
  assign bus8.out_ready = out_ready; assign bus3.out_ready = out_ready;
  assign bus8.a_in = a_in;        assign bus3.a_in = a_in;
  assign bus8.b_in = b_in;        assign bus3.b_in = b_in;
  assign bus8.x0_in = x0_in;      assign bus3.x0_in = x0_in;

  div_iter_ctrl #(.MAX_ITER(8), .CNT_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  div_iter_ctrl #(.MAX_ITER(3), .CNT_W(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: Newton-Raphson on plain integers, keeping x to its low signed byte
  function automatic exp_t model(int a, int b, int x0, int max_it, int acc);
    exp_t e;
    int x, xn, k;
    e.acc = acc;
    if (b == 0) begin
      e.q = '0; e.x = '0; e.cnt = '0; e.conv = 1'b0; e.err = 1'b1; e.lat = 0;
      return e;
    end
    x = x0; k = 0; e.conv = 1'b0;
    for (int i = 0; i < max_it; i++) begin
      xn = int'(byte'((2 - b * x) * x));
      k = i + 1;
      if (xn == x) begin
        e.conv = 1'b1;
        break;
      end
      x = xn;
    end
    e.x = 8'(x); e.q = 16'(a * x); e.cnt = 4'(k); e.err = 1'b0; e.lat = k + 1;
    return e;
  endfunction

  task automatic mon(input int id, input logic v, input logic signed [15:0] q,
                     input logic signed [7:0] x, input logic [3:0] cnt,
                     input logic conv, input logic err);
    exp_t e;
    int sz;
    if (!v) return;
    if (!have[id]) begin
      have[id] = 1'b1;
      sz = (id == 0) ? sb8.size() : sb3.size();
      if (sz == 0) begin
        bogus[id] = 1'b1;
        chk($sformatf("unexpected_result_d%0d", id), 1, 0);
      end else begin
        bogus[id] = 1'b0;
        if (id == 0) e = sb8.pop_front(); else e = sb3.pop_front();
        cur[id] = e;
        chk($sformatf("q_out_d%0d", id), q, e.q);
        chk($sformatf("x_out_d%0d", id), x, e.x);
        chk($sformatf("iter_cnt_d%0d", id), cnt, e.cnt);
        chk($sformatf("converged_d%0d", id), conv, e.conv);
        chk($sformatf("div_err_d%0d", id), err, e.err);
        chk($sformatf("latency_d%0d", id), cyc - e.acc, e.lat);
      end
    end else if (!bogus[id]) begin
      chk($sformatf("hold_q_d%0d", id), q, cur[id].q);
      chk($sformatf("hold_x_d%0d", id), x, cur[id].x);
      chk($sformatf("hold_cnt_d%0d", id), cnt, cur[id].cnt);
      chk($sformatf("hold_conv_d%0d", id), conv, cur[id].conv);
      chk($sformatf("hold_err_d%0d", id), err, cur[id].err);
    end
    if (out_ready || flush) have[id] = 1'b0;
  endtask

  // Monitor: compares every presented result against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      have[0] = 1'b0; have[1] = 1'b0;
    end else begin
      mon(0, bus8.out_valid, bus8.q_out, bus8.x_out, bus8.iter_cnt, bus8.converged, bus8.div_err);
      mon(1, bus3.out_valid, bus3.q_out, bus3.x_out, bus3.iter_cnt, bus3.converged, bus3.div_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_ready8"}, bus8.ready, 1);     chk({tag, "_ready3"}, bus3.ready, 1);
    chk({tag, "_busy8"}, bus8.busy, 0);       chk({tag, "_busy3"}, bus3.busy, 0);
    chk({tag, "_valid8"}, bus8.out_valid, 0); chk({tag, "_valid3"}, bus3.out_valid, 0);
    chk({tag, "_q8"}, bus8.q_out, 0);         chk({tag, "_q3"}, bus3.q_out, 0);
    chk({tag, "_x8"}, bus8.x_out, 0);         chk({tag, "_cnt8"}, bus8.iter_cnt, 0);
    chk({tag, "_conv8"}, bus8.converged, 0);  chk({tag, "_err8"}, bus8.div_err, 0);
  endtask

  task automatic issue(input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic signed [7:0] x0, input bit push, input bit bp);
    int n = 0;
    while (!(bus8.ready && bus3.ready) && n < 100) begin
      if (bp) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (n >= 100) begin
      chk("issue_ready_timeout", 1, 0);
      return;
    end
    a_in = a; b_in = b; x0_in = x0; start = 1'b1;
    if (push) begin
      sb8.push_back(model(int'(a), int'(b), int'(x0), 8, cyc + 1));
      sb3.push_back(model(int'(a), int'(b), int'(x0), 3, cyc + 1));
    end
    tick();
    start = 1'b0;
    if (bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (!(sb8.size() == 0 && sb3.size() == 0 && bus8.ready && bus3.ready) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle("in_reset");
    rst_n = 1'b1;
    tick();
    chk_idle("after_reset");

    // Fast convergence, then multi-step / timeout split across the two instances
    out_ready = 1'b1;
    issue(8'sd5, 8'sd1, 8'sd1, 1, 0);
    drain();
    issue(8'sd5, 8'sd1, 8'sd3, 1, 0);
    drain();

    // Zero divisor with 5 cycles of back-pressure
    out_ready = 1'b0;
    issue(8'sd7, 8'sd0, 8'sd1, 1, 0);
    chk("zdiv_valid8", bus8.out_valid, 1);
    chk("zdiv_err8", bus8.div_err, 1);
    chk("zdiv_q8", bus8.q_out, 0);
    repeat (5) tick();
    chk("zdiv_still_valid8", bus8.out_valid, 1);
    chk("zdiv_not_ready8", bus8.ready, 0);
    out_ready = 1'b1;
    tick();
    chk("zdiv_release_ready8", bus8.ready, 1);
    chk("zdiv_release_ready3", bus3.ready, 1);
    chk("zdiv_release_valid8", bus8.out_valid, 0);

    // Flush sampled on E2 while both instances iterate
    issue(8'sd5, 8'sd1, 8'sd3, 0, 0);
    tick();
    chk("pre_flush_busy8", bus8.busy, 1);
    chk("pre_flush_busy3", bus3.busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_idle("post_flush");
    repeat (6) begin
      tick();
      chk("flush_no_valid8", bus8.out_valid, 0);
      chk("flush_no_valid3", bus3.out_valid, 0);
    end

    // Start while iterating must be ignored
    issue(8'sd5, 8'sd1, 8'sd3, 1, 0);
    a_in = 8'sd9; b_in = 8'sd2; x0_in = 8'sd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_busy8", bus8.busy, 1);
    drain();

    // Flush in HOLD drops the result like out_ready
    out_ready = 1'b0;
    issue(-8'sd7, 8'sd0, 8'sd4, 1, 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("hold_flush_ready8", bus8.ready, 1);
    chk("hold_flush_valid8", bus8.out_valid, 0);

    // Randomized operands with random consumer back-pressure
    for (int n = 0; n < 60; n++) begin
      logic signed [7:0] ra, rb, rx;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'sd0 : 8'($urandom);
      rx = ($urandom_range(0, 3) == 0) ? 8'sd1 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 8'sd1;
      issue(ra, rb, rx, 1, 1);
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    drain();

    // Asynchronous reset mid-iteration
    issue(8'sd5, 8'sd1, 8'sd3, 0, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("after_async_reset");
    chk("sb_empty8", sb8.size(), 0);
    chk("sb_empty3", sb3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_iter_ctrl.md
Name: div_iter_ctrl

Overview:
- Sequential controller for the team's combinational 8-bit Newton-Raphson stage `divider` (A, B, xi -> Ni = A*xi, Di = B*xi, xinew = (2 - Di[7:0])*xi).
- Loads operands and seed, feeds x back through the stage once per clock until x stops changing or MAX_ITER is reached, then forms the quotient A*x_final.
- Presents the result on a valid/ready output handshake; sits between the operand source and the consumer of the quotient.

Parameters:
- MAX_ITER, 8, maximum iterations before forced stop (1..2^CNT_W-1).
- CNT_W, 4, width of the iteration counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when ready=1.
- ready  out  1  high in IDLE only.
- a_in  in  8  signed dividend, sampled on accept.
- b_in  in  8  signed divisor, sampled on accept.
- x0_in  in  8  signed seed reciprocal, sampled on accept.
- flush  in  1  synchronous abort to IDLE, no result produced.
- busy  out  1  high in ITER or FIN.
- out_valid  out  1  result valid, high in HOLD.
- out_ready  in  1  consumer accepts result.
- q_out  out  16  signed quotient A*x_final (stage Ni).
- x_out  out  8  final x.
- iter_cnt  out  CNT_W  iterations performed.
- converged  out  1  1 = stopped on fixed point, 0 = stopped on MAX_ITER.
- div_err  out  1  divisor was zero.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except ready=1; internal a/b/x regs 0.
- States IDLE, ITER, FIN, HOLD.
- IDLE: ready=1. On start=1, latch a_in/b_in/x0_in, clear iter_cnt.
  - b_in==0: go to HOLD with div_err=1, q_out=0, x_out=0, converged=0, iter_cnt=0.
  - Otherwise go to ITER.
- ITER, each cycle: drive stage with (a_reg, b_reg, x_reg); x_reg <= xinew[7:0] (truncation, no saturation); iter_cnt+1.
  - xinew[7:0]==x_reg: go to FIN, converged=1.
  - Else new iter_cnt==MAX_ITER: go to FIN, converged=0.
  - Else stay in ITER.
- FIN (one cycle): stage driven with the updated x_reg; q_out <= Ni; x_out <= x_reg; go to HOLD.
- HOLD: out_valid=1; q_out, x_out, iter_cnt, converged, div_err stable. On out_ready=1, go to IDLE next cycle. out_valid falls with that edge.
- Latency: accept edge E0, k iteration edges E1..Ek, FIN edge Ek+1. out_valid is high after Ek+1. Zero divisor gives out_valid after E0.
- start while ready=0: ignored, not queued.
- flush=1 in ITER or FIN: go to IDLE next edge; out_valid stays 0; result regs cleared.
  - flush in HOLD: same as out_ready (result dropped).
  - flush in IDLE: no effect; flush has priority over start.
- out_ready while out_valid=0: ignored.
- All arithmetic is signed two's complement. Widths: products 16 bits, x and operands 8 bits.
- Result registers change only on the FIN edge, the zero-divisor accept, flush or reset.

Decomposition:
- Shared package `div_pkg`:
  - state enum {IDLE, ITER, FIN, HOLD}.
  - DATA_W=8 and PROD_W=16 constants.
  - CONST_TWO=8'sd2.
- One sub-module: the existing combinational stage `divider`, instantiated once and time-shared across iterations and FIN.
- FSM, counter and result registers stay in div_iter_ctrl.

Test Plan:
- Fast convergence: a=5, b=1, x0=1.
  - Stage gives xinew=1 on E1, FIN on E2.
  - out_valid after E2 with q_out=5, x_out=1, iter_cnt=1, converged=1.
- Multi-step: a=5, b=1, x0=3, MAX_ITER=8.
  - x sequence 0x03 -> 0xFD -> 0xF1 -> 0x01 -> 0x01.
  - iter_cnt=4, converged=1, x_out=0x01, q_out=5, out_valid after E5.
- Timeout: same stimulus with MAX_ITER=3.
  - Stops after 3rd iteration with x_out=0x01, iter_cnt=3, converged=0, q_out=5.
- Zero divisor: a=7, b=0, x0=1.
  - Next cycle out_valid=1, div_err=1, q_out=0.
  - Hold out_ready=0 for 5 cycles and check outputs are stable; assert out_ready and check IDLE with ready=1.
- Abort and back-pressure, a=5, b=1, x0=3:
  - flush on E2: IDLE next edge, out_valid never rises.
  - start pulsed in ITER on a separate run: ignored.
  - rst_n low mid-ITER: outputs zero immediately, without waiting for a clock edge.
